// File: rtl/ws2812b_pkg.sv
// Shared constants and types for the WS2812B stream receiver.
// Timing values are in clock cycles at the nominal 64 MHz system clock.
package ws2812b_pkg;

  // Nominal bit-cell timing emitted by our driver
  localparam int T0H = 26;
  localparam int T1H = 51;
  localparam int T0L = 54;
  localparam int T1L = 29;

  // Decoder thresholds
  localparam int T1_MIN       = 38;
  localparam int HIGH_MAX     = 128;
  localparam int RESET_CYCLES = 3200;
  localparam int CNT_W        = 12;

  // One GRB pixel
  localparam int PIXEL_W = 24;

  typedef enum logic [1:0] {
    S_RESYNC,
    S_IDLE,
    S_HIGH,
    S_LOW
  } rx_state_t;

endpackage

// File: rtl/ws2812b_rx_sync.sv
// Input conditioning for the asynchronous serial line: two-flop synchroniser
// followed by one delay flop so that single-cycle edge strobes can be formed.
module ws2812b_rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic s1;
  logic s2;
  logic s3;

  // Synchroniser chain plus delayed copy for edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign level = s2;
  assign rise  = s2 & ~s3;
  assign fall  = ~s2 & s3;

endmodule

// File: rtl/ws2812b_rx.sv
// WS2812B single-wire receiver: measures high-pulse widths to recover 24-bit
// GRB pixels, detects the low reset/latch gap and counts pixels per frame.
// Optional build macro WS2812B_RX_FWD_EN enables forwarding of pixels 2..N
// of each frame on dout; without it dout is tied low.
module ws2812b_rx #(
  parameter int T1_MIN       = ws2812b_pkg::T1_MIN,
  parameter int HIGH_MAX     = ws2812b_pkg::HIGH_MAX,
  parameter int RESET_CYCLES = ws2812b_pkg::RESET_CYCLES,
  parameter int CNT_W        = ws2812b_pkg::CNT_W
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            din,
  input  logic                            err_clr,
  output logic [ws2812b_pkg::PIXEL_W-1:0] data,
  output logic                            data_valid,
  output logic                            latch,
  output logic [7:0]                      pixel_count,
  output logic                            error,
  output logic                            dout
);

  import ws2812b_pkg::*;

  logic level;
  logic rise;
  logic fall;

  rx_state_t          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [4:0]         bitcnt_q, bitcnt_d;
  logic [PIXEL_W-2:0] shreg_q, shreg_d;
  logic [PIXEL_W-1:0] shifted;
  logic [PIXEL_W-1:0] data_d;
  logic               dv_d;
  logic               latch_d;
  logic [7:0]         pcount_d;
  logic               err_set;
  logic               error_d;

  ws2812b_rx_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .din   (din),
    .level (level),
    .rise  (rise),
    .fall  (fall)
  );

  // Register the decoder state and all registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_RESYNC;
      cnt_q       <= '0;
      bitcnt_q    <= '0;
      shreg_q     <= '0;
      data        <= '0;
      data_valid  <= 1'b0;
      latch       <= 1'b0;
      pixel_count <= '0;
      error       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bitcnt_q    <= bitcnt_d;
      shreg_q     <= shreg_d;
      data        <= data_d;
      data_valid  <= dv_d;
      latch       <= latch_d;
      pixel_count <= pcount_d;
      error       <= error_d;
    end
  end

  // Next-state decode: pulse measurement, bit assembly, gap and error detection
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bitcnt_d = bitcnt_q;
    shreg_d  = shreg_q;
    data_d   = data;
    dv_d     = 1'b0;
    latch_d  = 1'b0;
    pcount_d = pixel_count;
    err_set  = 1'b0;
    cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
    shifted  = {shreg_q, (cnt_q >= CNT_W'(T1_MIN))};

    case (state_q)
      S_RESYNC: begin
        if (level) begin
          cnt_d = '0;
        end else if (cnt_inc == CNT_W'(RESET_CYCLES)) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_IDLE: begin
        if (rise) begin
          state_d  = S_HIGH;
          cnt_d    = CNT_W'(1);
          pcount_d = '0;
        end
      end
      S_HIGH: begin
        if (fall) begin
          shreg_d = shifted[PIXEL_W-2:0];
          state_d = S_LOW;
          cnt_d   = CNT_W'(1);
          if (bitcnt_q == 5'(PIXEL_W - 1)) begin
            data_d   = shifted;
            dv_d     = 1'b1;
            bitcnt_d = '0;
            pcount_d = (pixel_count == 8'hFF) ? pixel_count : pixel_count + 8'd1;
          end else begin
            bitcnt_d = bitcnt_q + 5'd1;
          end
        end else if (cnt_inc > CNT_W'(HIGH_MAX)) begin
          err_set  = 1'b1;
          state_d  = S_RESYNC;
          cnt_d    = '0;
          bitcnt_d = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_LOW: begin
        if (rise) begin
          state_d = S_HIGH;
          cnt_d   = CNT_W'(1);
        end else if (cnt_inc == CNT_W'(RESET_CYCLES)) begin
          latch_d  = 1'b1;
          state_d  = S_IDLE;
          cnt_d    = '0;
          err_set  = (bitcnt_q != '0);
          bitcnt_d = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = S_RESYNC;
    endcase

    if (err_set) begin
      error_d = 1'b1;
    end else if (err_clr) begin
      error_d = 1'b0;
    end else begin
      error_d = error;
    end
  end

`ifdef WS2812B_RX_FWD_EN
  logic fwd_active;

  // Forward window opens at the first pixel of a frame, closes on latch or resync
  always_ff @(posedge clk) begin
    if (reset) begin
      fwd_active <= 1'b0;
    end else if (latch_d || (state_d == S_RESYNC)) begin
      fwd_active <= 1'b0;
    end else if (dv_d) begin
      fwd_active <= 1'b1;
    end
  end

  assign dout = level & fwd_active;
`else
  assign dout = 1'b0;
`endif

endmodule
